room_thermal_model: RTL

- Cycle-based plant model of a room that closes the loop around the temperature controller.
- Consumes the controller's cooler/heater commands and produces the signed 32-bit room temperature the controller reads.
- Temperature changes once per thermal tick. It supports saturation, a disturbance-injection port and a sticky fault when heater and cooler fight.
- Used in system-level benches and on-board demo builds.

---
 rtl/room_thermal_model_if.sv | 21 ++
 rtl/room_thermal_model.sv | 126 ++++++++++++
 2 files changed

// File: rtl/room_thermal_model_if.sv
// rtl/room_thermal_model_if.sv - controller <-> room plant signal bundle
interface room_thermal_model_if;
  logic               cooler;
  logic               heater;
  logic               load_en;
  logic signed [31:0] load_temp;
  logic signed [31:0] temp;
  logic               temp_valid;
  logic               saturated;
  logic               fault;

  modport master (
    output cooler, heater, load_en, load_temp,
    input  temp, temp_valid, saturated, fault
  );

  modport slave (
    input  cooler, heater, load_en, load_temp,
    output temp, temp_valid, saturated, fault
  );
endinterface

// File: rtl/room_thermal_model.sv
// rtl/room_thermal_model.sv - tick-based room temperature plant with clamp, disturbance load and conflict fault
module room_thermal_model #(
  parameter int STEP_CYCLES = 8,
  parameter int INIT_TEMP   = 25,
  parameter int AMBIENT     = 25,
  parameter int HEAT_RATE   = 2,
  parameter int COOL_RATE   = 2,
  parameter int DRIFT_RATE  = 1,
  parameter int TEMP_MIN    = -40,
  parameter int TEMP_MAX    = 120,
  parameter int FAULT_TICKS = 4
) (
  input logic                 clock,
  input logic                 reset,
  room_thermal_model_if.slave bus
);
  localparam int PW = $clog2(STEP_CYCLES);
  localparam int CW = $clog2(FAULT_TICKS + 1);

  localparam logic signed [32:0] MIN33   = 33'(TEMP_MIN);
  localparam logic signed [32:0] MAX33   = 33'(TEMP_MAX);
  localparam logic signed [32:0] AMB33   = 33'(AMBIENT);
  localparam logic signed [32:0] HEAT33  = 33'(HEAT_RATE);
  localparam logic signed [32:0] COOL33  = 33'(COOL_RATE);
  localparam logic signed [32:0] DRIFT33 = 33'(DRIFT_RATE);

  typedef enum logic [1:0] {DRIFT, HEAT, COOL, CONFLICT} mode_t;

  mode_t              state, state_next;
  logic [PW-1:0]      pcount, pcount_next;
  logic [CW-1:0]      ccount, ccount_next;
  logic signed [31:0] temp_q, temp_next;
  logic               valid_q, valid_next;
  logic               sat_q, sat_next;
  logic               fault_q, fault_next;
  logic               tick;
  logic signed [32:0] wide;
  logic signed [32:0] diff;

  // All arithmetic is done one bit wider so the clamp sees the true value, never a wrapped one.
  function automatic logic signed [31:0] clamp(input logic signed [32:0] v);
    if (v < MIN33)
      return 32'(MIN33);
    else if (v > MAX33)
      return 32'(MAX33);
    else
      return 32'(v);
  endfunction

  assign tick = (pcount == PW'(STEP_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= DRIFT;
      pcount  <= '0;
      ccount  <= '0;
      temp_q  <= INIT_TEMP;
      valid_q <= 1'b0;
      sat_q   <= (INIT_TEMP == TEMP_MIN) || (INIT_TEMP == TEMP_MAX);
      fault_q <= 1'b0;
    end else begin
      state   <= state_next;
      pcount  <= pcount_next;
      ccount  <= ccount_next;
      temp_q  <= temp_next;
      valid_q <= valid_next;
      sat_q   <= sat_next;
      fault_q <= fault_next;
    end
  end

  always_comb begin
    state_next  = state;
    pcount_next = tick ? '0 : pcount + 1'b1;
    ccount_next = ccount;
    temp_next   = temp_q;
    valid_next  = 1'b0;
    fault_next  = fault_q;
    wide        = {temp_q[31], temp_q};
    diff        = wide - AMB33;

    // A disturbance load overrides a coincident tick and restarts the tick period.
    if (bus.load_en) begin
      pcount_next = '0;
      temp_next   = clamp({bus.load_temp[31], bus.load_temp});
      valid_next  = 1'b1;
    end else if (tick) begin
      valid_next = 1'b1;
      unique case ({bus.heater, bus.cooler})
        2'b10: begin
          state_next = HEAT;
          wide       = wide + HEAT33;
        end
        2'b01: begin
          state_next = COOL;
          wide       = wide - COOL33;
        end
        2'b11: state_next = CONFLICT;
        default: begin
          state_next = DRIFT;
          if (diff > DRIFT33)
            wide = wide - DRIFT33;
          else if (diff < -DRIFT33)
            wide = wide + DRIFT33;
          else
            wide = AMB33;
        end
      endcase
      temp_next = clamp(wide);

      if (bus.heater && bus.cooler)
        ccount_next = (ccount == CW'(FAULT_TICKS)) ? ccount : ccount + 1'b1;
      else
        ccount_next = '0;
      if (ccount_next == CW'(FAULT_TICKS))
        fault_next = 1'b1;
    end

    sat_next = (temp_next == TEMP_MIN) || (temp_next == TEMP_MAX);
  end

  assign bus.temp       = temp_q;
  assign bus.temp_valid = valid_q;
  assign bus.saturated  = sat_q;
  assign bus.fault      = fault_q;
endmodule
